// File: rtl/twi_bus_arbiter_if.sv
// Signal bundle shared by the two codec requesters, the TWI bus arbiter and TWICtl.
// slave = arbiter view; master = requester/controller side (driven by the bench).
interface twi_bus_arbiter_if;
   logic       req0;
   logic       req1;
   logic       gnt0;
   logic       gnt1;
   logic       msg0;
   logic       msg1;
   logic       stb0;
   logic       stb1;
   logic [7:0] addr0;
   logic [7:0] addr1;
   logic [7:0] din0;
   logic [7:0] din1;
   logic       done0;
   logic       done1;
   logic       err0;
   logic       err1;
   logic [7:0] dout;
   logic       twi_msg;
   logic       twi_stb;
   logic [7:0] twi_addr;
   logic [7:0] twi_din;
   logic [7:0] twi_dout;
   logic       twi_done;
   logic       twi_err;
   logic       timeout;

   modport slave (
      input  req0, req1, msg0, msg1, stb0, stb1, addr0, addr1, din0, din1,
             twi_dout, twi_done, twi_err,
      output gnt0, gnt1, done0, done1, err0, err1, dout,
             twi_msg, twi_stb, twi_addr, twi_din, timeout
   );

   modport master (
      output req0, req1, msg0, msg1, stb0, stb1, addr0, addr1, din0, din1,
             twi_dout, twi_done, twi_err,
      input  gnt0, gnt1, done0, done1, err0, err1, dout,
             twi_msg, twi_stb, twi_addr, twi_din, timeout
   );
endinterface

// File: rtl/twi_bus_arbiter.sv
// Whole-transaction arbiter sharing one TWICtl between codec init (req0) and runtime access (req1).
// Optional owner hold timeout enabled by defining TWI_ARB_TIMEOUT_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no owner; TWICtl strobe/msg held low; arbitrate pending reqs
//   OWN0    | requester 0 owns TWICtl; its msg/stb/addr/din are muxed out
//   OWN1    | requester 1 owns TWICtl; its msg/stb/addr/din are muxed out
//   RELEASE | one cycle with no owner so TWICtl sees STB low before handover
module twi_bus_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
`ifdef TWI_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 2_400_000
`endif
) (
   input  logic             clk,
   input  logic             rst,
   twi_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2,
      ST_REL  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       rr_last_q, rr_last_d;
   logic       own0;
   logic       own1;
   logic [1:0] req_ok;
   logic       tmo_hit;

   assign own0 = (state_q == ST_OWN0);
   assign own1 = (state_q == ST_OWN1);

`ifdef TWI_ARB_TIMEOUT_EN
   localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYC - 1);

   logic [21:0] hold_q, hold_d;
   logic        tmo_q, tmo_d;
   logic [1:0]  tmo_err_q, tmo_err_d;
   logic [1:0]  blk_q, blk_d;

   // A timed-out owner stays blocked until it lets go of its req.
   assign req_ok  = {bus.req1, bus.req0} & ~blk_q;
   assign tmo_hit = (own0 || own1) && (hold_q == TMO_LAST);

   always_comb begin
      hold_d    = '0;
      tmo_d     = 1'b0;
      tmo_err_d = 2'b00;
      blk_d     = blk_q & {bus.req1, bus.req0};
      if (own0 || own1) begin
         hold_d = bus.twi_done ? '0 : hold_q + 22'd1;
      end
      if (tmo_hit) begin
         tmo_d     = 1'b1;
         tmo_err_d = {own1, own0};
         blk_d     = blk_d | {own1, own0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q    <= '0;
         tmo_q     <= 1'b0;
         tmo_err_q <= 2'b00;
         blk_q     <= 2'b00;
      end else begin
         hold_q    <= hold_d;
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
         blk_q     <= blk_d;
      end
   end

   assign bus.err0    = (own0 & bus.twi_err) | tmo_err_q[0];
   assign bus.err1    = (own1 & bus.twi_err) | tmo_err_q[1];
   assign bus.timeout = tmo_q;
`else
   assign req_ok      = {bus.req1, bus.req0};
   assign tmo_hit     = 1'b0;
   assign bus.err0    = own0 & bus.twi_err;
   assign bus.err1    = own1 & bus.twi_err;
   assign bus.timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      case (state_q)
         ST_IDLE: begin
            // rr_last names the most recent owner; the other side wins a tie.
            if (req_ok == 2'b11) begin
               state_d = (FIXED_PRIO || rr_last_q) ? ST_OWN0 : ST_OWN1;
            end else if (req_ok[0]) begin
               state_d = ST_OWN0;
            end else if (req_ok[1]) begin
               state_d = ST_OWN1;
            end
         end
         ST_OWN0: begin
            if (!bus.req0 || tmo_hit) begin
               state_d   = ST_REL;
               rr_last_d = 1'b0;
            end
         end
         ST_OWN1: begin
            if (!bus.req1 || tmo_hit) begin
               state_d   = ST_REL;
               rr_last_d = 1'b1;
            end
         end
         ST_REL:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rr_last_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign bus.gnt0     = own0;
   assign bus.gnt1     = own1;
   assign bus.twi_msg  = own0 ? bus.msg0  : (own1 ? bus.msg1  : 1'b0);
   assign bus.twi_stb  = own0 ? bus.stb0  : (own1 ? bus.stb1  : 1'b0);
   assign bus.twi_addr = own0 ? bus.addr0 : (own1 ? bus.addr1 : 8'h00);
   assign bus.twi_din  = own0 ? bus.din0  : (own1 ? bus.din1  : 8'h00);
   assign bus.done0    = own0 & bus.twi_done;
   assign bus.done1    = own1 & bus.twi_done;
   assign bus.dout     = bus.twi_dout;

endmodule

// File: tb/tb_twi_bus_arbiter.sv
// Directed bench for twi_bus_arbiter: reset, round-robin, handover timing, non-owner isolation,
// mid-transaction reset and (with TWI_ARB_TIMEOUT_EN) the forced release.
module tb_twi_bus_arbiter;
   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;
   logic [7:0] wr_bytes [2] = '{8'h40, 8'h15};

   twi_bus_arbiter_if bus ();

   twi_bus_arbiter #(
      .FIXED_PRIO (1'b0)
`ifdef TWI_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC (100)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.req0     = 1'b0;
      bus.req1     = 1'b0;
      bus.msg0     = 1'b0;
      bus.msg1     = 1'b0;
      bus.stb0     = 1'b0;
      bus.stb1     = 1'b0;
      bus.addr0    = 8'h00;
      bus.addr1    = 8'h00;
      bus.din0     = 8'h00;
      bus.din1     = 8'h00;
      bus.twi_dout = 8'h00;
      bus.twi_done = 1'b0;
      bus.twi_err  = 1'b0;
      tick();
      tick();
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_twi_stb", bus.twi_stb, 0);
      chk("rst_twi_msg", bus.twi_msg, 0);
      chk("rst_twi_addr", bus.twi_addr, 8'h00);
      chk("rst_twi_din", bus.twi_din, 8'h00);
      chk("rst_done0", bus.done0, 0);
      chk("rst_err1", bus.err1, 0);
      chk("rst_timeout", bus.timeout, 0);
      rst = 1'b0;

      // Both request together straight after reset: req0 is favoured first.
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      settle();
      chk("gnt0_not_yet", bus.gnt0, 0);
      tick();
      chk("rr1_gnt0", bus.gnt0, 1);
      chk("rr1_gnt1", bus.gnt1, 0);

      bus.addr0 = 8'h76;
      for (int i = 0; i < 2; i++) begin
         bus.din0 = wr_bytes[i];
         bus.stb0 = 1'b1;
         settle();
         chk("wr_twi_addr", bus.twi_addr, 8'h76);
         chk("wr_twi_din", bus.twi_din, 32'(wr_bytes[i]));
         chk("wr_twi_stb", bus.twi_stb, 1);
         tick();
         bus.twi_done = 1'b1;
         settle();
         chk("wr_done0", bus.done0, 1);
         chk("wr_done1_gated", bus.done1, 0);
         tick();
         bus.twi_done = 1'b0;
      end
      bus.twi_dout = 8'hA5;
      settle();
      chk("dout_bcast", bus.dout, 8'hA5);

      // Non-owner strobes with its own address: nothing reaches TWICtl.
      bus.stb0  = 1'b0;
      bus.stb1  = 1'b1;
      bus.msg1  = 1'b1;
      bus.addr1 = 8'h55;
      settle();
      chk("nonown_addr", bus.twi_addr, 8'h76);
      chk("nonown_stb", bus.twi_stb, 0);
      chk("nonown_msg", bus.twi_msg, 0);
      tick();
      bus.stb1 = 1'b0;
      bus.msg1 = 1'b0;

      // Owner drops req with stb still high; release cycle must mask it.
      bus.stb0 = 1'b1;
      bus.req0 = 1'b0;
      tick();
      chk("rel_gnt0", bus.gnt0, 0);
      chk("rel_gnt1", bus.gnt1, 0);
      chk("rel_stb", bus.twi_stb, 0);
      bus.twi_done = 1'b1;
      bus.twi_err  = 1'b1;
      settle();
      chk("rel_done0", bus.done0, 0);
      chk("rel_done1", bus.done1, 0);
      chk("rel_err0", bus.err0, 0);
      bus.twi_done = 1'b0;
      bus.twi_err  = 1'b0;
      bus.stb0     = 1'b0;
      bus.req0     = 1'b1;
      tick();
      chk("idle_gnt1", bus.gnt1, 0);
      tick();
      chk("handover_gnt1", bus.gnt1, 1);
      chk("handover_gnt0", bus.gnt0, 0);

      bus.stb1 = 1'b1;
      bus.din1 = 8'h0C;
      bus.msg1 = 1'b1;
      settle();
      chk("own1_addr", bus.twi_addr, 8'h55);
      chk("own1_din", bus.twi_din, 8'h0C);
      chk("own1_msg", bus.twi_msg, 1);
      bus.twi_done = 1'b1;
      settle();
      chk("own1_done1", bus.done1, 1);
      chk("own1_done0", bus.done0, 0);
      tick();
      bus.twi_done = 1'b0;
      bus.stb1     = 1'b0;
      bus.msg1     = 1'b0;

      // Third arbitration with both pending goes back to req0.
      bus.req1 = 1'b0;
      tick();
      bus.req1 = 1'b1;
      tick();
      tick();
      chk("rr3_gnt0", bus.gnt0, 1);
      chk("rr3_gnt1", bus.gnt1, 0);
      bus.req0 = 1'b0;
      tick();
      tick();
      tick();
      chk("rr4_gnt1", bus.gnt1, 1);

      // Reset in the middle of a req1 byte.
      bus.stb1 = 1'b1;
      settle();
      chk("pre_rst_stb", bus.twi_stb, 1);
      rst = 1'b1;
      tick();
      chk("midrst_gnt1", bus.gnt1, 0);
      chk("midrst_stb", bus.twi_stb, 0);
      rst = 1'b0;
      tick();
      chk("postrst_gnt1", bus.gnt1, 1);

      bus.stb1 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      tick();
      chk("quiet_gnt0", bus.gnt0, 0);
      chk("quiet_gnt1", bus.gnt1, 0);
      bus.req0 = 1'b1;
      tick();
      chk("hold_gnt0", bus.gnt0, 1);
      bus.req1 = 1'b1;
`ifdef TWI_ARB_TIMEOUT_EN
      repeat (99) tick();
      chk("tmo_pre_gnt0", bus.gnt0, 1);
      chk("tmo_pre_timeout", bus.timeout, 0);
      chk("tmo_pre_err0", bus.err0, 0);
      tick();
      chk("tmo_timeout", bus.timeout, 1);
      chk("tmo_err0", bus.err0, 1);
      chk("tmo_err1", bus.err1, 0);
      chk("tmo_gnt0", bus.gnt0, 0);
      tick();
      chk("tmo_pulse_end", bus.timeout, 0);
      chk("tmo_err0_end", bus.err0, 0);
      tick();
      chk("tmo_next_gnt1", bus.gnt1, 1);
      bus.req1 = 1'b0;
      tick();
      tick();
      tick();
      chk("tmo_blocked_gnt0", bus.gnt0, 0);
      bus.req0 = 1'b0;
      tick();
      bus.req0 = 1'b1;
      tick();
      chk("tmo_regrant_gnt0", bus.gnt0, 1);
`else
      repeat (150) tick();
      chk("nomacro_gnt0", bus.gnt0, 1);
      chk("nomacro_timeout", bus.timeout, 0);
      chk("nomacro_err0", bus.err0, 0);
      bus.req0 = 1'b0;
      tick();
      tick();
      tick();
      chk("nomacro_gnt1", bus.gnt1, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
